// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the flag/branch path.
//   - Flag bit positions inside a status word {V,E,N,C,Z} (bit0 = Z).
//   - 4-bit branch condition codes.
//   - eval_cond(): pure branch resolution against a flag word.
package cpu_pkg;

  localparam int FLAG_W = 5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;  // borrow after SUB
  localparam int FLAG_N = 2;
  localparam int FLAG_E = 3;
  localparam int FLAG_V = 4;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_EV = 4'd9,
    COND_OD = 4'd10,
    COND_HI = 4'd11,
    COND_LS = 4'd12,
    COND_GE = 4'd13,
    COND_LT = 4'd14,
    COND_GT = 4'd15
  } cond_e;

  function automatic logic eval_cond(input logic [3:0] cond,
                                     input logic [FLAG_W-1:0] f);
    logic z, c, n, e, v;
    logic res;
    z   = f[FLAG_Z];
    c   = f[FLAG_C];
    n   = f[FLAG_N];
    e   = f[FLAG_E];
    v   = f[FLAG_V];
    res = 1'b0;
    case (cond)
      COND_AL: res = 1'b1;
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_EV: res = e;
      COND_OD: res = ~e;
      COND_HI: res = ~c & ~z;
      COND_LS: res = c | z;
      COND_GE: res = n ~^ v;
      COND_LT: res = n ^ v;
      COND_GT: res = ~z & (n ~^ v);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Bus between the CPU core (master) and flag_unit (slave).
//   master drives: alu_f* flags, flag_we, cond/cond_valid, push/pop
//   slave drives : flags, take/take_valid, stack_full/empty/err
interface flag_unit_if;
  import cpu_pkg::*;

  logic              alu_fz;
  logic              alu_fc;
  logic              alu_fn;
  logic              alu_fe;
  logic              alu_fv;
  logic              flag_we;
  logic [3:0]        cond;
  logic              cond_valid;
  logic              push;
  logic              pop;
  logic [FLAG_W-1:0] flags;
  logic              take;
  logic              take_valid;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output alu_fz, alu_fc, alu_fn, alu_fe, alu_fv, flag_we,
    output cond, cond_valid, push, pop,
    input  flags, take, take_valid, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  alu_fz, alu_fc, alu_fn, alu_fe, alu_fv, flag_we,
    input  cond, cond_valid, push, pop,
    output flags, take, take_valid, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/flag_stack.sv
// LIFO of saved flag words used on interrupt entry/exit.
//   i_push/i_pop : requested operations (both at once is illegal)
//   i_wdata      : word saved on a legal push
//   o_rdata      : top-of-stack word (valid when o_pop_ok)
//   o_pop_ok     : a legal pop happens this cycle (combinational)
//   o_full/o_empty : registered occupancy, derived from the pointer
//   o_err        : one-cycle pulse after an illegal op (push-full,
//                  pop-empty, push+pop); illegal ops change nothing
// STACK_DEPTH must be a power of two, >= 2.
module flag_stack
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [FLAG_W-1:0] i_wdata,
  output logic [FLAG_W-1:0] o_rdata,
  output logic              o_pop_ok,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int PW = AW + 1;  // one extra bit so "full" is representable
  localparam logic [PW-1:0] FULL_CNT = PW'(STACK_DEPTH);

  logic [FLAG_W-1:0] r_mem [STACK_DEPTH];
  logic [PW-1:0]     r_sp;
  logic              r_full;
  logic              r_empty;
  logic              r_err;

  logic [PW-1:0]     w_sp_next;
  logic [AW-1:0]     w_top_idx;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_err;

  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_err     = 1'b0;
    w_sp_next = r_sp;
    if (i_push && i_pop) begin
      w_err = 1'b1;
    end else if (i_push) begin
      if (r_full) w_err = 1'b1;
      else        w_do_push = 1'b1;
    end else if (i_pop) begin
      if (r_empty) w_err = 1'b1;
      else         w_do_pop = 1'b1;
    end
    if (w_do_push)     w_sp_next = r_sp + PW'(1);
    else if (w_do_pop) w_sp_next = r_sp - PW'(1);
  end

  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign o_rdata   = r_mem[w_top_idx];
  assign o_pop_ok  = w_do_pop;
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_sp    <= w_sp_next;
      r_full  <= (w_sp_next == FULL_CNT);
      r_empty <= (w_sp_next == '0);
      r_err   <= w_err;
    end
  end

  // NOTE: storage is deliberately not reset; the pointer alone defines
  // which words are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_sp[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural status register and branch resolver.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : flag_unit_if.slave
//     alu_f*/flag_we  -> latch ALU flags into the status register
//     cond/cond_valid -> registered take/take_valid one cycle later
//     push/pop        -> save/restore flags via flag_stack
// The "effective" flags seen by conditions and pushes bypass a same-
// cycle flag_we; a legal pop wins over flag_we and becomes visible on
// the next cycle.
module flag_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  flag_unit_if.slave bus
);

  logic [FLAG_W-1:0] r_flags;
  logic              r_take;
  logic              r_take_valid;

  logic [FLAG_W-1:0] w_alu_flags;
  logic [FLAG_W-1:0] w_eff;
  logic [FLAG_W-1:0] w_stack_rdata;
  logic              w_pop_ok;

  assign w_alu_flags = {bus.alu_fv, bus.alu_fe, bus.alu_fn, bus.alu_fc, bus.alu_fz};
  assign w_eff       = bus.flag_we ? w_alu_flags : r_flags;

  flag_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (bus.push),
    .i_pop    (bus.pop),
    .i_wdata  (w_eff),
    .o_rdata  (w_stack_rdata),
    .o_pop_ok (w_pop_ok),
    .o_full   (bus.stack_full),
    .o_empty  (bus.stack_empty),
    .o_err    (bus.stack_err)
  );

  // NOTE: non-blocking assignments so every register samples the
  // pre-edge values; the condition therefore sees the pre-pop flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags      <= '0;
      r_take       <= 1'b0;
      r_take_valid <= 1'b0;
    end else begin
      if (w_pop_ok)         r_flags <= w_stack_rdata;
      else if (bus.flag_we) r_flags <= w_alu_flags;
      r_take_valid <= bus.cond_valid;
      if (bus.cond_valid) r_take <= eval_cond(bus.cond, w_eff);
    end
  end

  assign bus.flags      = r_flags;
  assign bus.take       = r_take;
  assign bus.take_valid = r_take_valid;

endmodule
